// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// multicycle_ctrl_pkg: opcode, funct, ALU and state encodings for the MIPS control FSM.
// Rev 1.0
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if: IR/ALU-flag inputs and datapath control outputs of the FSM.
// Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       PC_en;
   logic       IorD;
   logic       mem_write;
   logic       IR_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       ALU_src_A;
   logic [1:0] ALU_src_B;
   logic [2:0] ALU_control;
   logic [1:0] PC_src;
   logic       illegal_op;

   modport master (
      input  opcode, funct, zero,
      output PC_en, IorD, mem_write, IR_write, reg_dst, mem_to_reg, reg_write,
             ALU_src_A, ALU_src_B, ALU_control, PC_src, illegal_op
   );

   modport slave (
      output opcode, funct, zero,
      input  PC_en, IorD, mem_write, IR_write, reg_dst, mem_to_reg, reg_write,
             ALU_src_A, ALU_src_B, ALU_control, PC_src, illegal_op
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ============================================================================
// alu_decoder: maps ALU_op and funct to the 3-bit ALU_control code.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_ok
);

   always_comb begin
      alu_control = ALUC_ADD;
      funct_ok    = 1'b1;
      case (alu_op)
         ALUOP_SUB:   alu_control = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alu_control = ALUC_ADD;
               FUNCT_SUB: alu_control = ALUC_SUB;
               FUNCT_AND: alu_control = ALUC_AND;
               FUNCT_OR:  alu_control = ALUC_OR;
               FUNCT_SLT: alu_control = ALUC_SLT;
               // Unsupported funct keeps the add code; the FSM routes to ILLEGAL.
               default:   funct_ok    = 1'b0;
            endcase
         end
         default:     alu_control = ALUC_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   multicycle_ctrl_if.master bus
);

   state_e     state_q;
   state_e     state_d;
   alu_op_e    alu_op;
   logic [2:0] alu_control;
   logic       funct_ok;

   logic       pc_write;
   logic       branch;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       iord;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       src_a;
   logic [1:0] src_b;
   logic [1:0] pc_src;
   logic       illegal;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (bus.funct),
      .alu_control (alu_control),
      .funct_ok    (funct_ok)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = S_FETCH;
         S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_ILLEGAL;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_ILLEGAL;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      iord       = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      src_a      = 1'b0;
      src_b      = 2'b00;
      pc_src     = 2'b00;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            src_b    = 2'b01;
         end
         S_DECODE:  src_b = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            src_a = 1'b1;
            src_b = 2'b10;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            src_a  = 1'b1;
            alu_op = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            src_a  = 1'b1;
            alu_op = ALUOP_SUB;
            pc_src = 2'b01;
            branch = 1'b1;
         end
         S_ADDIWB:  reg_write = 1'b1;
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_ILLEGAL: illegal = 1'b1;
         default:   illegal = 1'b1;
      endcase
   end

   // Strobes are gated by resetn so an in-flight write dies the moment reset falls.
   assign bus.PC_en       = resetn & (pc_write | (branch & bus.zero));
   assign bus.IR_write    = resetn & ir_write;
   assign bus.mem_write   = resetn & mem_write;
   assign bus.reg_write   = resetn & reg_write;
   assign bus.IorD        = iord;
   assign bus.reg_dst     = reg_dst;
   assign bus.mem_to_reg  = mem_to_reg;
   assign bus.ALU_src_A   = src_a;
   assign bus.ALU_src_B   = src_b;
   assign bus.ALU_control = alu_control;
   assign bus.PC_src      = pc_src;
   assign bus.illegal_op  = illegal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl: scoreboard bench for the multicycle MIPS control FSM.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_J     = 6'b000010;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       src_a;
      logic [1:0] src_b;
      logic [2:0] aluc;
      logic [1:0] pc_src;
      logic       illegal;
   } ctl_t;

   logic clk;
   logic resetn;
   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   ctl_t exp_q[$];
   ctl_t exp_w;
   ctl_t act_w;
   int   checks = 0;
   int   errors = 0;
   logic [5:0] legal_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit funct_known(logic [5:0] fn);
      return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
             (fn == 6'b100101) || (fn == 6'b101010);
   endfunction

   function automatic logic [2:0] funct_code(logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic ctl_t base_word();
      ctl_t w = '0;
      w.aluc = 3'b010;
      return w;
   endfunction

   function automatic ctl_t rst_word();
      ctl_t w = base_word();
      w.src_b = 2'b01;
      return w;
   endfunction

   function automatic ctl_t illegal_word();
      ctl_t w = base_word();
      w.illegal = 1'b1;
      return w;
   endfunction

   function automatic int n_steps(logic [5:0] op, logic [5:0] fn);
      case (op)
         T_LW:          return 5;
         T_SW, T_ADDI:  return 4;
         T_RTYPE:       return funct_known(fn) ? 4 : 3;
         T_BEQ, T_J:    return 3;
         default:       return 2;
      endcase
   endfunction

   // Expected control word for cycle 'step' of one instruction.
   function automatic ctl_t expect_step(logic [5:0] op, logic [5:0] fn, int step, logic z);
      ctl_t w = base_word();
      if (step == 0) begin
         w.pc_en = 1'b1; w.ir_write = 1'b1; w.src_b = 2'b01;
         return w;
      end
      if (step == 1) begin
         w.src_b = 2'b11;
         return w;
      end
      case (op)
         T_LW: begin
            if (step == 2) begin w.src_a = 1'b1; w.src_b = 2'b10; end
            else if (step == 3) w.iord = 1'b1;
            else begin w.mem_to_reg = 1'b1; w.reg_write = 1'b1; end
         end
         T_SW: begin
            if (step == 2) begin w.src_a = 1'b1; w.src_b = 2'b10; end
            else begin w.iord = 1'b1; w.mem_write = 1'b1; end
         end
         T_RTYPE: begin
            if (step == 2) begin w.src_a = 1'b1; w.aluc = funct_code(fn); end
            else if (!funct_known(fn)) w = illegal_word();
            else begin w.reg_dst = 1'b1; w.reg_write = 1'b1; end
         end
         T_BEQ: begin
            w.src_a = 1'b1; w.aluc = 3'b110; w.pc_src = 2'b01; w.pc_en = z;
         end
         T_ADDI: begin
            if (step == 2) begin w.src_a = 1'b1; w.src_b = 2'b10; end
            else w.reg_write = 1'b1;
         end
         T_J: begin
            w.pc_src = 2'b10; w.pc_en = 1'b1;
         end
         default: w = illegal_word();
      endcase
      return w;
   endfunction

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         resetn = 1'b0;
         bus.opcode = 6'($urandom);
         bus.funct  = 6'($urandom);
         exp_q.push_back(rst_word());
      end
   endtask

   // zforce<0 randomizes zero; abort_step>=0 pulls resetn low in that cycle.
   task automatic run_instr(logic [5:0] op, logic [5:0] fn, int zforce, int abort_step, int extra);
      int   n;
      logic z;
      ctl_t w;
      n = n_steps(op, fn) + extra;
      for (int s = 0; s < n; s++) begin
         @(posedge clk); #1;
         if (s == 0) begin
            resetn = 1'b1;
            bus.opcode = op;
            bus.funct  = fn;
         end
         z = (zforce < 0) ? 1'($urandom_range(0, 1)) : zforce[0];
         bus.zero = z;
         if (s == abort_step) begin
            resetn = 1'b0;
            exp_q.push_back(rst_word());
            break;
         end
         w = expect_step(op, fn, s, z);
         if (w.illegal) begin
            bus.opcode = 6'($urandom);
            bus.funct  = 6'($urandom);
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic run_random();
      logic [5:0] fn;
      fn = 6'($urandom);
      case ($urandom_range(0, 5))
         0: run_instr(T_LW, fn, -1, -1, 0);
         1: run_instr(T_SW, fn, -1, -1, 0);
         2: run_instr(T_RTYPE, legal_f[$urandom_range(0, 4)], -1, -1, 0);
         3: run_instr(T_BEQ, fn, -1, -1, 0);
         4: run_instr(T_ADDI, fn, -1, -1, 0);
         default: run_instr(T_J, fn, -1, -1, 0);
      endcase
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         act_w = {bus.PC_en, bus.IorD, bus.mem_write, bus.IR_write, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.ALU_src_A, bus.ALU_src_B,
                  bus.ALU_control, bus.PC_src, bus.illegal_op};
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL ctl_word t=%0t actual=%b required=%b (pc_en,iord,mw,irw,rdst,m2r,rw,A,B2,aluc3,pcsrc2,ill)",
                     $time, act_w, exp_w);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      bus.opcode = '0;
      bus.funct  = '0;
      bus.zero   = 1'b0;
      do_reset(3);

      run_instr(T_LW,    6'b000000, -1, -1, 0);
      run_instr(T_RTYPE, 6'b101010, -1, -1, 0);
      run_instr(T_RTYPE, 6'b100100, -1, -1, 0);
      run_instr(T_BEQ,   6'b000000,  1, -1, 0);
      run_instr(T_BEQ,   6'b000000,  0, -1, 0);
      run_instr(T_SW,    6'b000000, -1, -1, 0);
      run_instr(T_ADDI,  6'b000000, -1, -1, 0);
      run_instr(T_J,     6'b000000, -1, -1, 0);

      for (int i = 0; i < 40; i++) run_random();

      // Reset lands in the write-back cycle of a load.
      run_instr(T_LW, 6'b000000, -1, 4, 0);
      do_reset(2);
      run_instr(T_ADDI, 6'b000000, -1, -1, 0);

      run_instr(6'b111111, 6'b000000, -1, -1, 5);
      do_reset(2);
      run_instr(T_RTYPE, 6'b000111, -1, -1, 5);
      do_reset(2);
      run_instr(T_LW, 6'b000000, -1, -1, 0);

      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
